instr_fifo_q: RTL and testbench

Parametrised fetch-to-backend instruction queue between the fetch unit and the back-end issue stage. Buffers up to DEPTH fetched instructions with their PC, branch prediction and fetch exception. Decouples the fetch valid/ready handshake from the issue side and adds:
- an occupancy count;
- an optional fall-through mode;
- flush;
- an exception lock that stops fetch acceptance after an excepting instruction.

---
 rtl/instr_fifo_q.sv | 92 +++++++++
 tb/tb_instr_fifo_q.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_fifo_q.sv
// instr_fifo_q: fetch-to-issue instruction queue with occupancy count, optional fall-through, flush and exception lock
// Ports: clk_i/rst_i (async active-high reset), flush_i;
//   fetch side: fetch_valid_i/fetch_ready_o, curr_pc_i, instruction_i, pred_target_i, pred_taken_i, except_raised_i, except_code_i;
//   issue side: issue_valid_o/issue_ready_i, issue_pc_o, issue_instr_o, issue_pred_target_o, issue_pred_taken_o,
//   issue_except_raised_o, issue_except_code_o; status: count_o, except_lock_o.
module instr_fifo_q #(
    parameter int DEPTH        = 4,
    parameter int XLEN         = 64,
    parameter int ILEN         = 32,
    parameter int EXCW         = 4,
    parameter int FALL_THROUGH = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [XLEN-1:0]            curr_pc_i,
    input  logic [ILEN-1:0]            instruction_i,
    input  logic [XLEN-1:0]            pred_target_i,
    input  logic                       pred_taken_i,
    input  logic                       except_raised_i,
    input  logic [EXCW-1:0]            except_code_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic [XLEN-1:0]            issue_pc_o,
    output logic [ILEN-1:0]            issue_instr_o,
    output logic [XLEN-1:0]            issue_pred_target_o,
    output logic                       issue_pred_taken_o,
    output logic                       issue_except_raised_o,
    output logic [EXCW-1:0]            issue_except_code_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       except_lock_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 2*XLEN + ILEN + 2 + EXCW;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          lock;
    logic          full, empty, push, pop, ft_pass, wr, rd;
    logic [EW-1:0] din, dout;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    // Ready never looks at issue_ready_i, so issue cannot combinationally stall fetch.
    assign fetch_ready_o = !rst_i & !full & !lock & !flush_i;
    assign push = fetch_valid_i & fetch_ready_o;
    // Fall-through: an empty queue presents the incoming instruction directly.
    assign ft_pass = (FALL_THROUGH != 0) & empty & push;
    assign issue_valid_o = (!empty & !flush_i & !rst_i) | ft_pass;
    assign pop = issue_valid_o & issue_ready_i;
    // A fall-through instruction consumed in the same cycle is never written.
    assign wr = push & !(ft_pass & issue_ready_i);
    assign rd = pop & !empty;
    assign din = {curr_pc_i, instruction_i, pred_target_i, pred_taken_i, except_raised_i, except_code_i};
    assign dout = ft_pass ? din : mem[head];
    assign {issue_pc_o, issue_instr_o, issue_pred_target_o, issue_pred_taken_o,
            issue_except_raised_o, issue_except_code_o} = dout;
    assign count_o = count;
    assign except_lock_o = lock;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            lock  <= 1'b0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            lock  <= 1'b0;
        end else begin
            if (wr) tail <= tail + PW'(1);
            if (rd) head <= head + PW'(1);
            count <= (wr & !rd) ? count + CW'(1) : (!wr & rd) ? count - CW'(1) : count;
            if (push & except_raised_i) lock <= 1'b1;
        end
    end

    // Storage is cleared only by reset; flush leaves stale contents behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[tail] <= din;
        end
    end
endmodule

// File: tb/tb_instr_fifo_q.sv
// tb_instr_fifo_q: scoreboard bench for instr_fifo_q (main instance FALL_THROUGH=0, second instance FALL_THROUGH=1)
module tb_instr_fifo_q;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        fv = 1'b0, ir = 1'b0, ptk = 1'b0, exc = 1'b0;
    logic [63:0] pc = '0, tgt = '0;
    logic [31:0] ins = '0;
    logic [3:0]  code = '0;

    logic        rdy, iv, itk, iexc, lk;
    logic [63:0] ipc, itgt;
    logic [31:0] iins;
    logic [3:0]  icode;
    logic [2:0]  cnt;

    logic        f_rdy, f_iv, f_itk, f_iexc, f_lk;
    logic [63:0] f_ipc, f_itgt;
    logic [31:0] f_iins;
    logic [3:0]  f_icode;
    logic [2:0]  f_cnt;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic [63:0] tgt;
        logic        tk;
        logic        exc;
        logic [3:0]  code;
    } ent_t;

    ent_t q[$];
    bit   lock_m = 0;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    instr_fifo_q #(.DEPTH(4), .FALL_THROUGH(0)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .fetch_valid_i(fv), .fetch_ready_o(rdy),
        .curr_pc_i(pc), .instruction_i(ins), .pred_target_i(tgt), .pred_taken_i(ptk),
        .except_raised_i(exc), .except_code_i(code), .issue_valid_o(iv), .issue_ready_i(ir),
        .issue_pc_o(ipc), .issue_instr_o(iins), .issue_pred_target_o(itgt), .issue_pred_taken_o(itk),
        .issue_except_raised_o(iexc), .issue_except_code_o(icode), .count_o(cnt), .except_lock_o(lk)
    );

    instr_fifo_q #(.DEPTH(4), .FALL_THROUGH(1)) dut_ft (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .fetch_valid_i(fv), .fetch_ready_o(f_rdy),
        .curr_pc_i(pc), .instruction_i(ins), .pred_target_i(tgt), .pred_taken_i(ptk),
        .except_raised_i(exc), .except_code_i(code), .issue_valid_o(f_iv), .issue_ready_i(ir),
        .issue_pc_o(f_ipc), .issue_instr_o(f_iins), .issue_pred_target_o(f_itgt), .issue_pred_taken_o(f_itk),
        .issue_except_raised_o(f_iexc), .issue_except_code_o(f_icode), .count_o(f_cnt), .except_lock_o(f_lk)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle (inputs set just after a rising edge), check against the model, advance past the next edge.
    task automatic cyc(input bit v, input logic [63:0] p, input bit e, input logic [3:0] c,
                       input bit r, input bit f, input bit ft);
        ent_t n;
        bit   er;
        n.pc = p; n.ins = 32'hDEAD_0000 | {16'h0, p[15:0]}; n.tgt = p + 64'h1000 + (p << 1);
        n.tk = p[2] ^ p[3]; n.exc = e; n.code = c;
        fv = v; pc = n.pc; ins = n.ins; tgt = n.tgt; ptk = n.tk; exc = e; code = c; ir = r; flush = f;
        #1;
        er = (q.size() < 4) && !lock_m && !f;
        chk("count", cnt, q.size());
        chk("lock", lk, lock_m);
        chk("fetch_ready", rdy, er);
        chk("issue_valid", iv, (q.size() > 0) && !f);
        if (q.size() > 0 && !f) begin
            chk("issue_pc", ipc, q[0].pc);
            chk("issue_instr", iins, q[0].ins);
            chk("issue_target", itgt, q[0].tgt);
            chk("issue_taken", itk, q[0].tk);
            chk("issue_exc", iexc, q[0].exc);
            chk("issue_code", icode, q[0].code);
            if (r) void'(q.pop_front());
        end
        if (ft) begin
            chk("ft_issue_valid", f_iv, 1);
            chk("ft_issue_pc", f_ipc, p);
            chk("ft_issue_instr", f_iins, n.ins);
        end
        if (v && er) begin
            q.push_back(n);
            if (e) lock_m = 1;
        end
        if (f) begin
            q.delete();
            lock_m = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_fetch_ready", rdy, 0);
        chk("rst_issue_valid", iv, 0);
        chk("rst_count", cnt, 0);
        chk("rst_issue_pc", ipc, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("idle_fetch_ready", rdy, 1);
        chk("idle_issue_valid", iv, 0);
        chk("idle_count", cnt, 0);
        chk("idle_issue_pc", ipc, 0);
        chk("idle_issue_instr", iins, 0);
        chk("idle_issue_target", itgt, 0);
        chk("idle_issue_code", icode, 0);
        @(posedge clk);
        #1;
        // Fill, then drain with a rejected push while full
        for (int i = 0; i < 4; i++) cyc(1, 64'(4*i), 0, 0, 0, 0, 0);
        chk("full_count", cnt, 4);
        chk("full_fetch_ready", rdy, 0);
        cyc(1, 64'h99, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("drained_count", cnt, 0);
        // Continuous push+pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1, 64'h100 + 64'(4*i), 0, 0, 1, 0, 0);
            chk("stream_count", cnt, 1);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
        // Exception lock
        cyc(1, 64'h10, 0, 0, 0, 0, 0);
        cyc(1, 64'h14, 1, 4'h1, 0, 0, 0);
        chk("lock_set", lk, 1);
        chk("lock_ready", rdy, 0);
        cyc(1, 64'h18, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("lock_cleared", lk, 0);
        // Flush with 3 queued
        for (int i = 0; i < 3; i++) cyc(1, 64'h20 + 64'(4*i), 0, 0, 0, 0, 0);
        cyc(1, 64'h50, 0, 0, 0, 1, 0);
        chk("flush_count", cnt, 0);
        chk("flush_valid", iv, 0);
        cyc(1, 64'h40, 0, 0, 0, 0, 0);
        chk("flush_head", ipc, 64'h40);
        cyc(0, 0, 0, 0, 1, 0, 0);
        // Asynchronous reset mid-operation
        cyc(1, 64'h60, 0, 0, 0, 0, 0);
        cyc(1, 64'h64, 0, 0, 0, 0, 0);
        rst = 1'b1;
        fv = 1'b0;
        #1;
        chk("async_rst_count", cnt, 0);
        chk("async_rst_valid", iv, 0);
        chk("async_rst_ready", rdy, 0);
        q.delete();
        lock_m = 0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        // Fall-through instance: zero latency, nothing stored
        cyc(1, 64'h80, 0, 0, 1, 0, 1);
        chk("ft_count", f_cnt, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("ft_valid_after", f_iv, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
